// File: rtl/fda_uart_pkg.sv
// Shared constants and FSM encoding for the UART capture streamer.
// STREAMER_HEADER_EN adds the header states to the state encoding.
package fda_uart_pkg;

    localparam logic [7:0] CMD_START = 8'h53;
    localparam logic [7:0] CMD_ABORT = 8'h58;
    localparam logic [7:0] CMD_CLEAR = 8'h43;
    localparam logic [7:0] HDR_SYNC  = 8'hA5;

`ifdef STREAMER_HEADER_EN
    typedef enum logic [2:0] {StIdle, StHdr, StHdrGap, StFetch, StSend} state_e;
`else
    typedef enum logic [1:0] {StIdle, StFetch, StSend} state_e;
`endif

endpackage

// File: rtl/streamer_ram.sv
// Simple dual-port capture buffer: one write port, one synchronous read port.
module streamer_ram #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_capture_streamer.sv
// Circular capture buffer streamed to the TxD FIFO channel under 'S'/'X'/'C' commands.
// Define STREAMER_HEADER_EN to prefix each stream with A5, Len[15:8], Len[7:0].
module uart_capture_streamer
    import fda_uart_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [7:0]        Cmd,
    input  logic              CmdValid,
    input  logic              WrEn,
    input  logic [7:0]        WrData,
    input  logic              DataReceived,
    output logic [7:0]        TxData,
    output logic              RequestToSend,
    output logic              Busy,
    output logic              Overflow,
    output logic [ADDR_W:0]   Count
);

    localparam int unsigned   DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, len_q;
    logic              overflow_q, abort_q;
    logic [7:0]        ram_rdata;

    logic cmd_start, cmd_abort, cmd_clear;
    logic full, push, pop, do_clear, rts;

    assign cmd_start = CmdValid && (Cmd == CMD_START);
    assign cmd_abort = CmdValid && (Cmd == CMD_ABORT);
    assign cmd_clear = CmdValid && (Cmd == CMD_CLEAR);
    assign do_clear  = cmd_clear && (state_q == StIdle);
    // Full is judged on the pre-edge count, so a same-cycle pop never admits the write.
    assign full      = (count_q == FULL);
    assign push      = WrEn && !full && !do_clear;
    assign pop       = DataReceived && (state_q == StSend);

`ifdef STREAMER_HEADER_EN
    logic [1:0]  hdr_idx_q;
    logic [15:0] len16;
    assign len16 = 16'(len_q);
`endif

    streamer_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (Clock),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (WrData),
        .rd_en   (state_q == StFetch),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rdata)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_start && (count_q != '0)) begin
`ifdef STREAMER_HEADER_EN
                    state_d = StHdr;
`else
                    state_d = StFetch;
`endif
                end
            end
`ifdef STREAMER_HEADER_EN
            StHdr: begin
                if (DataReceived) begin
                    if (cmd_abort || abort_q) state_d = StIdle;
                    else if (hdr_idx_q == 2'd2) state_d = StFetch;
                    else state_d = StHdrGap;
                end
            end
            StHdrGap: state_d = cmd_abort ? StIdle : StHdr;
`endif
            StFetch: state_d = cmd_abort ? StIdle : StSend;
            StSend: begin
                if (DataReceived) begin
                    if (cmd_abort || abort_q || (len_q == 1)) state_d = StIdle;
                    else state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        TxData        = '0;
        RequestToSend = 1'b0;
        Busy          = (state_q != StIdle);
        case (state_q)
            StSend: begin
                TxData        = ram_rdata;
                RequestToSend = 1'b1;
            end
`ifdef STREAMER_HEADER_EN
            StHdr: begin
                RequestToSend = 1'b1;
                case (hdr_idx_q)
                    2'd0:    TxData = HDR_SYNC;
                    2'd1:    TxData = len16[15:8];
                    default: TxData = len16[7:0];
                endcase
            end
`endif
            default: ;
        endcase
    end

    assign rts = RequestToSend;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            len_q      <= '0;
            overflow_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            if (do_clear) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
                if (WrEn && full) overflow_q <= 1'b1;
                if (push && !pop) count_q <= count_q + 1'b1;
                else if (pop && !push) count_q <= count_q - 1'b1;
            end
            if ((state_q == StIdle) && (state_d != StIdle)) len_q <= count_q;
            else if (pop) len_q <= len_q - 1'b1;
            // An abort seen mid-handshake is remembered until the byte is acknowledged.
            if (state_d == StIdle) abort_q <= 1'b0;
            else if (cmd_abort && rts) abort_q <= 1'b1;
        end
    end

`ifdef STREAMER_HEADER_EN
    always_ff @(posedge Clock) begin
        if (!Reset || (state_q == StIdle)) begin
            hdr_idx_q <= '0;
        end else if ((state_q == StHdr) && DataReceived) begin
            hdr_idx_q <= hdr_idx_q + 1'b1;
        end
    end
`endif

    assign Count    = count_q;
    assign Overflow = overflow_q;

endmodule

// File: tb/tb_uart_capture_streamer.sv
// Scoreboard bench for uart_capture_streamer (ADDR_W=2, depth 4); works with or without
// STREAMER_HEADER_EN.
module tb_uart_capture_streamer;
    import fda_uart_pkg::*;

    localparam int unsigned ADDR_W = 2;
`ifdef STREAMER_HEADER_EN
    localparam int HDR_N = 3;
`else
    localparam int HDR_N = 0;
`endif

    logic            Clock = 1'b0;
    logic            Reset = 1'b0;
    logic [7:0]      Cmd = '0;
    logic            CmdValid = 1'b0;
    logic            WrEn = 1'b0;
    logic [7:0]      WrData = '0;
    logic            DataReceived = 1'b0;
    logic [7:0]      TxData;
    logic            RequestToSend;
    logic            Busy;
    logic            Overflow;
    logic [ADDR_W:0] Count;

    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] exp_q[$];
    logic       rts_prev = 1'b0;

    uart_capture_streamer #(
        .ADDR_W (ADDR_W)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Cmd           (Cmd),
        .CmdValid      (CmdValid),
        .WrEn          (WrEn),
        .WrData        (WrData),
        .DataReceived  (DataReceived),
        .TxData        (TxData),
        .RequestToSend (RequestToSend),
        .Busy          (Busy),
        .Overflow      (Overflow),
        .Count         (Count)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Monitor: every new byte presentation is compared against the scoreboard head.
    always @(negedge Clock) begin
        if (RequestToSend && !rts_prev) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL tx_unexpected: got byte 0x%02h, expected no byte", TxData);
            end else begin
                check("tx_byte", int'(TxData), int'(exp_q.pop_front()));
            end
        end
        rts_prev = RequestToSend;
    end

    task automatic wr(input logic [7:0] b);
        WrEn = 1'b1;
        WrData = b;
        @(negedge Clock);
        WrEn = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        Cmd = c;
        CmdValid = 1'b1;
        @(negedge Clock);
        CmdValid = 1'b0;
        Cmd = '0;
    endtask

    task automatic push_hdr(input int len);
        if (HDR_N > 0) begin
            exp_q.push_back(HDR_SYNC);
            exp_q.push_back(8'(len >> 8));
            exp_q.push_back(8'(len));
        end
    endtask

    task automatic wait_rts(input string name);
        int n = 0;
        while (!RequestToSend && n < 30) begin
            @(negedge Clock);
            n++;
        end
        if (!RequestToSend) begin
            n_total++;
            $display("FAIL %s: RequestToSend low, required high within 30 cycles", name);
        end
    endtask

    task automatic ack_one();
        wait_rts("ack_wait");
        repeat (2) @(negedge Clock);
        DataReceived = 1'b1;
        @(negedge Clock);
        DataReceived = 1'b0;
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge Clock);
        check("rst_count", Count, 0);
        check("rst_busy", Busy, 0);
        check("rst_ovf", Overflow, 0);
        check("rst_rts", RequestToSend, 0);
        check("rst_txdata", TxData, 0);
        Reset = 1'b1;
        @(negedge Clock);

        // Basic three-byte stream
        wr(8'h10); wr(8'h11); wr(8'h12);
        check("t1_count3", Count, 3);
        push_hdr(3);
        exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'h12);
        send_cmd(CMD_START);
        check("t1_rts_edge1", RequestToSend, (HDR_N > 0) ? 1 : 0);
        @(negedge Clock);
        check("t1_rts_edge2", RequestToSend, 1);
        repeat (3 + HDR_N) ack_one();
        check("t1_busy_done", Busy, 0);
        check("t1_count0", Count, 0);

        // Overflow and clear
        for (int i = 0; i < 5; i++) wr(8'(8'h20 + i));
        check("t2_count_full", Count, 4);
        check("t2_ovf_set", Overflow, 1);
        send_cmd(CMD_CLEAR);
        check("t2_count_clr", Count, 0);
        check("t2_ovf_clr", Overflow, 0);

        // Pointer wrap
        wr(8'h30); wr(8'h31);
        push_hdr(2);
        exp_q.push_back(8'h30); exp_q.push_back(8'h31);
        send_cmd(CMD_START);
        repeat (2 + HDR_N) ack_one();
        for (int i = 0; i < 4; i++) wr(8'(8'h32 + i));
        check("t3_count4", Count, 4);
        push_hdr(4);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'h32 + i));
        send_cmd(CMD_START);
        repeat (4 + HDR_N) ack_one();
        check("t3_count0", Count, 0);
        check("t3_busy", Busy, 0);

        // Abort while a byte is being presented
        wr(8'h40); wr(8'h41); wr(8'h42);
        if (HDR_N > 0) exp_q.push_back(HDR_SYNC);
        else exp_q.push_back(8'h40);
        send_cmd(CMD_START);
        wait_rts("t4_rts");
        send_cmd(CMD_ABORT);
        check("t4_rts_held", RequestToSend, 1);
        check("t4_busy_held", Busy, 1);
        ack_one();
        check("t4_busy_idle", Busy, 0);
        check("t4_count_left", Count, (HDR_N > 0) ? 3 : 2);
        seen = 0;
        repeat (10) begin
            @(negedge Clock);
            if (RequestToSend) seen = 1;
        end
        check("t4_no_rts", seen, 0);
        send_cmd(CMD_CLEAR);

        // Write coinciding with a pop: full drops, non-full keeps Count
        for (int i = 0; i < 4; i++) wr(8'(8'h50 + i));
        push_hdr(4);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'h50 + i));
        send_cmd(CMD_START);
        repeat (HDR_N) ack_one();
        wait_rts("t5_first");
        WrEn = 1'b1; WrData = 8'h5F; DataReceived = 1'b1;
        @(negedge Clock);
        WrEn = 1'b0; DataReceived = 1'b0;
        check("t5_full_count", Count, 3);
        check("t5_full_ovf", Overflow, 1);
        ack_one();
        check("t5_count2", Count, 2);
        wait_rts("t5_third");
        WrEn = 1'b1; WrData = 8'h60; DataReceived = 1'b1;
        @(negedge Clock);
        WrEn = 1'b0; DataReceived = 1'b0;
        check("t5_pushpop_count", Count, 2);
        ack_one();
        check("t5_count1", Count, 1);
        check("t5_busy", Busy, 0);
        push_hdr(1);
        exp_q.push_back(8'h60);
        send_cmd(CMD_START);
        repeat (1 + HDR_N) ack_one();
        check("t5_count0", Count, 0);

        // Reset mid-payload
        wr(8'h70); wr(8'h71);
        push_hdr(2);
        exp_q.push_back(8'h70);
        send_cmd(CMD_START);
        repeat (HDR_N) ack_one();
        wait_rts("t6_payload");
        check("t6_ovf_before", Overflow, 1);
        Reset = 1'b0;
        @(negedge Clock);
        check("t6_rts", RequestToSend, 0);
        check("t6_txdata", TxData, 0);
        check("t6_busy", Busy, 0);
        check("t6_count", Count, 0);
        check("t6_ovf", Overflow, 0);
        Reset = 1'b1;
        @(negedge Clock);

        // Start with empty buffer is ignored
        send_cmd(CMD_START);
        check("t7_empty_busy", Busy, 0);
        @(negedge Clock);
        check("t7_empty_rts", RequestToSend, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
